dport_axi_slave: RTL and testbench

- AXI4 slave (responder) bridging AXI4 initiators to the single-word dcache_if-style memory port used by SoC RAM/peripherals.
- Accepts 32-bit INCR/FIXED bursts and issues one memory request per beat.
- One AXI transaction in flight, one memory request outstanding.
- Memory-side counterpart of the dcache_if -> AXI bridge; lets the CPU data port and the debug/bus masters share AXI-attached memory.

---
 rtl/dport_axi_slave.sv | 219 +++++++++++++++++++++
 tb/tb_dport_axi_slave.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dport_axi_slave.sv
// AXI4 slave that serialises one INCR/FIXED burst at a time onto a single-word
// request/accept/ack memory port, issuing one memory request per beat.
module dport_axi_slave #(
   parameter int ID_W = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            axi_awvalid_i,
   input  logic [31:0]     axi_awaddr_i,
   input  logic [ID_W-1:0] axi_awid_i,
   input  logic [7:0]      axi_awlen_i,
   input  logic [1:0]      axi_awburst_i,
   output logic            axi_awready_o,
   input  logic            axi_wvalid_i,
   input  logic [31:0]     axi_wdata_i,
   input  logic [3:0]      axi_wstrb_i,
   input  logic            axi_wlast_i,
   output logic            axi_wready_o,
   output logic            axi_bvalid_o,
   output logic [1:0]      axi_bresp_o,
   output logic [ID_W-1:0] axi_bid_o,
   input  logic            axi_bready_i,
   input  logic            axi_arvalid_i,
   input  logic [31:0]     axi_araddr_i,
   input  logic [ID_W-1:0] axi_arid_i,
   input  logic [7:0]      axi_arlen_i,
   input  logic [1:0]      axi_arburst_i,
   output logic            axi_arready_o,
   output logic            axi_rvalid_o,
   output logic [31:0]     axi_rdata_o,
   output logic [1:0]      axi_rresp_o,
   output logic [ID_W-1:0] axi_rid_o,
   output logic            axi_rlast_o,
   input  logic            axi_rready_i,
   output logic [31:0]     mem_addr_o,
   output logic [31:0]     mem_data_wr_o,
   output logic            mem_rd_o,
   output logic [3:0]      mem_wr_o,
   input  logic            mem_accept_i,
   input  logic            mem_ack_i,
   input  logic [31:0]     mem_data_rd_i,
   input  logic            mem_error_i
);

   typedef enum logic [2:0] {
      IDLE, WR_DATA, WR_MEM, WR_RESP, RD_REQ, RD_WAIT, RD_DATA
   } state_t;

   state_t          state_reg;
   logic [31:0]     addr_reg;
   logic [ID_W-1:0] id_reg;
   logic [7:0]      count_reg;
   logic [1:0]      burst_reg;
   logic [31:0]     wdata_reg;
   logic [3:0]      mem_wr_reg;
   logic            mem_rd_reg;
   logic            err_reg;
   logic            last_wr_reg;
   logic            bvalid_reg;
   logic [1:0]      bresp_reg;
   logic            rvalid_reg;
   logic [31:0]     rdata_reg;
   logic [1:0]      rresp_reg;
   logic            rlast_reg;

   logic            grant_wr;
   logic            grant_rd;
   logic [31:0]     addr_next;
   logic            unused_wlast;

   // Beat count comes from len alone, so wlast carries no information here.
   assign unused_wlast = axi_wlast_i;

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state_reg == IDLE) begin
         if (axi_awvalid_i && axi_arvalid_i) begin
            grant_wr = !last_wr_reg;
            grant_rd = last_wr_reg;
         end else begin
            grant_wr = axi_awvalid_i;
            grant_rd = axi_arvalid_i;
         end
      end
   end

   // FIXED holds the address; INCR and WRAP both step one word.
   assign addr_next = (burst_reg == 2'b00) ? addr_reg : addr_reg + 32'd4;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         id_reg      <= '0;
         count_reg   <= '0;
         burst_reg   <= '0;
         wdata_reg   <= '0;
         mem_wr_reg  <= '0;
         mem_rd_reg  <= 1'b0;
         err_reg     <= 1'b0;
         last_wr_reg <= 1'b0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= '0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         rresp_reg   <= '0;
         rlast_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_wr) begin
                  addr_reg    <= axi_awaddr_i;
                  id_reg      <= axi_awid_i;
                  count_reg   <= axi_awlen_i;
                  burst_reg   <= axi_awburst_i;
                  last_wr_reg <= 1'b1;
                  err_reg     <= 1'b0;
                  state_reg   <= WR_DATA;
               end else if (grant_rd) begin
                  addr_reg    <= axi_araddr_i;
                  id_reg      <= axi_arid_i;
                  count_reg   <= axi_arlen_i;
                  burst_reg   <= axi_arburst_i;
                  last_wr_reg <= 1'b0;
                  mem_rd_reg  <= 1'b1;
                  state_reg   <= RD_REQ;
               end
            end
            WR_DATA: begin
               if (axi_wvalid_i) begin
                  wdata_reg <= axi_wdata_i;
                  if (axi_wstrb_i != 4'h0) begin
                     mem_wr_reg <= axi_wstrb_i;
                     state_reg  <= WR_MEM;
                  end else if (count_reg == 8'd0) begin
                     bvalid_reg <= 1'b1;
                     bresp_reg  <= err_reg ? 2'b10 : 2'b00;
                     state_reg  <= WR_RESP;
                  end else begin
                     count_reg <= count_reg - 8'd1;
                     addr_reg  <= addr_next;
                  end
               end
            end
            WR_MEM: begin
               // A non-zero strobe register means the request is still unaccepted.
               if (mem_wr_reg != 4'h0) begin
                  if (mem_accept_i) mem_wr_reg <= 4'h0;
               end else if (mem_ack_i) begin
                  err_reg <= err_reg | mem_error_i;
                  if (count_reg == 8'd0) begin
                     bvalid_reg <= 1'b1;
                     bresp_reg  <= (err_reg | mem_error_i) ? 2'b10 : 2'b00;
                     state_reg  <= WR_RESP;
                  end else begin
                     count_reg <= count_reg - 8'd1;
                     addr_reg  <= addr_next;
                     state_reg <= WR_DATA;
                  end
               end
            end
            WR_RESP: begin
               if (axi_bready_i) begin
                  bvalid_reg <= 1'b0;
                  err_reg    <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
            RD_REQ: begin
               if (mem_accept_i) begin
                  mem_rd_reg <= 1'b0;
                  state_reg  <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_ack_i) begin
                  rdata_reg  <= mem_data_rd_i;
                  rresp_reg  <= mem_error_i ? 2'b10 : 2'b00;
                  rlast_reg  <= (count_reg == 8'd0);
                  rvalid_reg <= 1'b1;
                  state_reg  <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (axi_rready_i) begin
                  rvalid_reg <= 1'b0;
                  if (rlast_reg) begin
                     state_reg <= IDLE;
                  end else begin
                     count_reg  <= count_reg - 8'd1;
                     addr_reg   <= addr_next;
                     mem_rd_reg <= 1'b1;
                     state_reg  <= RD_REQ;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign axi_awready_o = grant_wr;
   assign axi_arready_o = grant_rd;
   assign axi_wready_o  = (state_reg == WR_DATA);
   assign axi_bvalid_o  = bvalid_reg;
   assign axi_bresp_o   = bresp_reg;
   assign axi_bid_o     = id_reg;
   assign axi_rvalid_o  = rvalid_reg;
   assign axi_rdata_o   = rdata_reg;
   assign axi_rresp_o   = rresp_reg;
   assign axi_rid_o     = id_reg;
   assign axi_rlast_o   = rlast_reg;
   assign mem_addr_o    = {addr_reg[31:2], 2'b00};
   assign mem_data_wr_o = wdata_reg;
   assign mem_rd_o      = mem_rd_reg;
   assign mem_wr_o      = mem_wr_reg;

endmodule

// File: tb/tb_dport_axi_slave.sv
// Directed bench for dport_axi_slave: a table of bursts against a scripted
// memory responder, plus hand sequences for arbitration and mid-burst reset.
module tb_dport_axi_slave;
   localparam int ID_W = 4;

   logic clk, rst;
   logic awvalid, awready, wvalid, wlast, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rlast, rready;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [ID_W-1:0] awid, arid, bid, rid;
   logic [7:0] awlen, arlen;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic [3:0] wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic mem_rd, mem_accept, mem_ack, mem_err;
   logic [3:0] mem_wr;

   dport_axi_slave #(.ID_W(ID_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .axi_awvalid_i(awvalid), .axi_awaddr_i(awaddr), .axi_awid_i(awid),
      .axi_awlen_i(awlen), .axi_awburst_i(awburst), .axi_awready_o(awready),
      .axi_wvalid_i(wvalid), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb),
      .axi_wlast_i(wlast), .axi_wready_o(wready),
      .axi_bvalid_o(bvalid), .axi_bresp_o(bresp), .axi_bid_o(bid), .axi_bready_i(bready),
      .axi_arvalid_i(arvalid), .axi_araddr_i(araddr), .axi_arid_i(arid),
      .axi_arlen_i(arlen), .axi_arburst_i(arburst), .axi_arready_o(arready),
      .axi_rvalid_o(rvalid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
      .axi_rid_o(rid), .axi_rlast_o(rlast), .axi_rready_i(rready),
      .mem_addr_o(mem_addr), .mem_data_wr_o(mem_wdata), .mem_rd_o(mem_rd),
      .mem_wr_o(mem_wr), .mem_accept_i(mem_accept), .mem_ack_i(mem_ack),
      .mem_data_rd_i(mem_rdata), .mem_error_i(mem_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Memory responder: accepts after stall_cfg cycles, acks the next cycle.
   logic [31:0] mem_model [256];
   logic [31:0] log_addr [$];
   logic [3:0]  log_strb [$];
   logic [31:0] log_data [$];
   bit          log_rd [$];
   int txn_base = 0;
   int err_op = -1;
   int stall_cfg = 0;
   bit no_ack = 1'b0;
   bit force_ack = 1'b0;

   initial begin : responder
      bit ack_due, ack_err, req_seen, req;
      logic [31:0] ack_data, req_addr;
      int stall_left;
      ack_due = 0; ack_err = 0; req_seen = 0; ack_data = '0; req_addr = '0; stall_left = 0;
      mem_accept = 0; mem_ack = 0; mem_rdata = '0; mem_err = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = ack_due || force_ack;
         mem_rdata = force_ack ? 32'hBAD0_BAD0 : ack_data;
         mem_err   = ack_due && ack_err;
         ack_due   = 0;
         mem_accept = 0;
         req = mem_rd || (mem_wr != 4'h0);
         if (rst) begin
            req_seen = 0;
         end else if (req) begin
            if (!req_seen) begin
               req_seen = 1;
               stall_left = stall_cfg;
               req_addr = mem_addr;
            end else begin
               check("mem_req_addr_held", mem_addr, req_addr);
            end
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               mem_accept = 1;
               ack_err = ((log_addr.size() - txn_base) == err_op);
               log_addr.push_back(mem_addr);
               log_strb.push_back(mem_wr);
               log_data.push_back(mem_wdata);
               log_rd.push_back(mem_rd);
               ack_due = !no_ack;
               ack_data = mem_model[mem_addr[9:2]];
               req_seen = 0;
            end
         end else if (req_seen) begin
            check("mem_req_held", {31'b0, req}, 32'd1);
            req_seen = 0;
         end
      end
   end

   function automatic logic sig(input int which);
      case (which)
         0: return awready;
         1: return arready;
         2: return wready;
         3: return bvalid;
         default: return rvalid;
      endcase
   endfunction

   // Called at a negedge; returns at negedge+1 with the signal high or on timeout.
   task automatic wait_sig(input int which, input string name, output int cycles);
      cycles = 0;
      #1;
      while (!sig(which) && cycles < 60) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      if (!sig(which)) begin
         checks++;
         failures++;
         $display("FAIL timeout_%s actual=low required=high", name);
      end
   endtask

   typedef struct {
      bit               is_wr;
      logic [31:0]      addr;
      logic [3:0]       id;
      logic [7:0]       len;
      logic [1:0]       burst;
      logic [3:0][31:0] wdata;
      logic [3:0][3:0]  wstrb;
      int               err_op;
      int               stall;
      int               rstall;
      int               n_ops;
      logic [3:0][31:0] exp_addr;
      logic [3:0][3:0]  exp_strb;
      logic [3:0][31:0] exp_data;
      logic [3:0][1:0]  exp_resp;
      int               exp_lat;
   } vec_t;

   vec_t vecs [8];

   task automatic run_vec(input int vi, input vec_t v);
      int base, cyc, n;
      logic [31:0] snap_data;
      logic snap_last;
      base = log_addr.size();
      txn_base = base;
      err_op = v.err_op;
      stall_cfg = v.stall;
      if (v.is_wr) begin
         awvalid = 1; awaddr = v.addr; awid = v.id; awlen = v.len; awburst = v.burst;
         wait_sig(0, "awready", cyc);
         @(negedge clk);
         awvalid = 0;
         for (int b = 0; b <= int'(v.len); b++) begin
            wvalid = 1; wdata = v.wdata[b]; wstrb = v.wstrb[b]; wlast = (b == int'(v.len));
            wait_sig(2, "wready", cyc);
            @(negedge clk);
            wvalid = 0; wlast = 0;
         end
         bready = 1;
         wait_sig(3, "bvalid", cyc);
         if (v.exp_lat != 0) check($sformatf("v%0d_b_latency", vi), cyc + 1, v.exp_lat);
         check($sformatf("v%0d_bresp", vi), {30'b0, bresp}, {30'b0, v.exp_resp[0]});
         check($sformatf("v%0d_bid", vi), {28'b0, bid}, {28'b0, v.id});
         @(negedge clk);
         bready = 0;
         check($sformatf("v%0d_bvalid_drop", vi), {31'b0, bvalid}, 32'd0);
      end else begin
         arvalid = 1; araddr = v.addr; arid = v.id; arlen = v.len; arburst = v.burst;
         wait_sig(1, "arready", cyc);
         @(negedge clk);
         arvalid = 0;
         for (int b = 0; b <= int'(v.len); b++) begin
            wait_sig(4, "rvalid", cyc);
            if (b == 0 && v.exp_lat != 0) check($sformatf("v%0d_r_latency", vi), cyc + 1, v.exp_lat);
            snap_data = rdata;
            snap_last = rlast;
            for (int k = 0; k < v.rstall; k++) begin
               @(negedge clk);
               check($sformatf("v%0d_b%0d_rvalid_held", vi, b), {31'b0, rvalid}, 32'd1);
               check($sformatf("v%0d_b%0d_rdata_stable", vi, b), rdata, snap_data);
               check($sformatf("v%0d_b%0d_rlast_stable", vi, b), {31'b0, rlast}, {31'b0, snap_last});
            end
            check($sformatf("v%0d_rdata%0d", vi, b), rdata, v.exp_data[b]);
            check($sformatf("v%0d_rresp%0d", vi, b), {30'b0, rresp}, {30'b0, v.exp_resp[b]});
            check($sformatf("v%0d_rlast%0d", vi, b), {31'b0, rlast}, {31'b0, b == int'(v.len)});
            check($sformatf("v%0d_rid%0d", vi, b), {28'b0, rid}, {28'b0, v.id});
            rready = 1;
            @(negedge clk);
            rready = 0;
         end
      end
      n = log_addr.size() - base;
      check($sformatf("v%0d_mem_ops", vi), n, v.n_ops);
      for (int i = 0; i < v.n_ops && i < n; i++) begin
         check($sformatf("v%0d_mem_addr%0d", vi, i), log_addr[base+i], v.exp_addr[i]);
         check($sformatf("v%0d_mem_strb%0d", vi, i), {28'b0, log_strb[base+i]}, {28'b0, v.exp_strb[i]});
         check($sformatf("v%0d_mem_rd%0d", vi, i), {31'b0, log_rd[base+i]}, {31'b0, !v.is_wr});
         if (v.is_wr) check($sformatf("v%0d_mem_wdata%0d", vi, i), log_data[base+i], v.exp_data[i]);
      end
      $display("txn v%0d %s addr=0x%08h len=%0d burst=%0d mem_ops=%0d", vi,
               v.is_wr ? "write" : "read", v.addr, v.len, v.burst, n);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int cyc, wbase;
      bit seen;
      rst = 1; awvalid = 0; awaddr = '0; awid = '0; awlen = '0; awburst = '0;
      wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
      arvalid = 0; araddr = '0; arid = '0; arlen = '0; arburst = '0; rready = 0;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'hC0DE_0000 | i;
      mem_model[8'h80] = 32'h11; mem_model[8'h81] = 32'h22;
      mem_model[8'h82] = 32'h33; mem_model[8'h83] = 32'h44;

      vecs[0] = '{is_wr:1'b1, addr:32'h100, id:4'h5, len:8'd0, burst:2'b01,
                  wdata:{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, wstrb:{4'h0, 4'h0, 4'h0, 4'hF},
                  err_op:-1, stall:0, rstall:0, n_ops:1,
                  exp_addr:{32'h0, 32'h0, 32'h0, 32'h100}, exp_strb:{4'h0, 4'h0, 4'h0, 4'hF},
                  exp_data:{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, exp_resp:{2'b0, 2'b0, 2'b0, 2'b00}, exp_lat:3};
      vecs[1] = '{is_wr:1'b0, addr:32'h200, id:4'h3, len:8'd3, burst:2'b01,
                  wdata:'0, wstrb:'0, err_op:-1, stall:0, rstall:2, n_ops:4,
                  exp_addr:{32'h20C, 32'h208, 32'h204, 32'h200}, exp_strb:'0,
                  exp_data:{32'h44, 32'h33, 32'h22, 32'h11}, exp_resp:'0, exp_lat:3};
      vecs[2] = '{is_wr:1'b1, addr:32'h300, id:4'h9, len:8'd2, burst:2'b01,
                  wdata:{32'h0, 32'hA2, 32'hA1, 32'hA0}, wstrb:{4'h0, 4'h0, 4'h3, 4'hF},
                  err_op:1, stall:0, rstall:0, n_ops:2,
                  exp_addr:{32'h0, 32'h0, 32'h304, 32'h300}, exp_strb:{4'h0, 4'h0, 4'h3, 4'hF},
                  exp_data:{32'h0, 32'h0, 32'hA1, 32'hA0}, exp_resp:{2'b0, 2'b0, 2'b0, 2'b10}, exp_lat:0};
      vecs[3] = '{is_wr:1'b0, addr:32'h10, id:4'hA, len:8'd0, burst:2'b01,
                  wdata:'0, wstrb:'0, err_op:0, stall:0, rstall:0, n_ops:1,
                  exp_addr:{32'h0, 32'h0, 32'h0, 32'h10}, exp_strb:'0,
                  exp_data:{32'h0, 32'h0, 32'h0, 32'hC0DE_0004}, exp_resp:{2'b0, 2'b0, 2'b0, 2'b10}, exp_lat:3};
      vecs[4] = '{is_wr:1'b0, addr:32'h40, id:4'h6, len:8'd1, burst:2'b00,
                  wdata:'0, wstrb:'0, err_op:-1, stall:5, rstall:0, n_ops:2,
                  exp_addr:{32'h0, 32'h0, 32'h40, 32'h40}, exp_strb:'0,
                  exp_data:{32'h0, 32'h0, 32'hC0DE_0010, 32'hC0DE_0010}, exp_resp:'0, exp_lat:0};
      vecs[5] = '{is_wr:1'b1, addr:32'h500, id:4'h1, len:8'd1, burst:2'b10,
                  wdata:{32'h0, 32'h0, 32'hB1, 32'hB0}, wstrb:{4'h0, 4'h0, 4'hF, 4'hF},
                  err_op:-1, stall:0, rstall:0, n_ops:2,
                  exp_addr:{32'h0, 32'h0, 32'h504, 32'h500}, exp_strb:{4'h0, 4'h0, 4'hF, 4'hF},
                  exp_data:{32'h0, 32'h0, 32'hB1, 32'hB0}, exp_resp:'0, exp_lat:0};
      vecs[6] = '{is_wr:1'b1, addr:32'h600, id:4'h2, len:8'd1, burst:2'b00,
                  wdata:{32'h0, 32'h0, 32'hC1, 32'hC0}, wstrb:{4'h0, 4'h0, 4'h1, 4'hC},
                  err_op:-1, stall:0, rstall:0, n_ops:2,
                  exp_addr:{32'h0, 32'h0, 32'h600, 32'h600}, exp_strb:{4'h0, 4'h0, 4'h1, 4'hC},
                  exp_data:{32'h0, 32'h0, 32'hC1, 32'hC0}, exp_resp:'0, exp_lat:0};
      vecs[7] = '{is_wr:1'b0, addr:32'h44, id:4'hF, len:8'd0, burst:2'b01,
                  wdata:'0, wstrb:'0, err_op:-1, stall:0, rstall:0, n_ops:1,
                  exp_addr:{32'h0, 32'h0, 32'h0, 32'h44}, exp_strb:'0,
                  exp_data:{32'h0, 32'h0, 32'h0, 32'hC0DE_0011}, exp_resp:'0, exp_lat:3};

      repeat (3) @(negedge clk);
      check("rst_awready", {31'b0, awready}, 32'd0);
      check("rst_arready", {31'b0, arready}, 32'd0);
      check("rst_wready", {31'b0, wready}, 32'd0);
      check("rst_bvalid", {31'b0, bvalid}, 32'd0);
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
      check("rst_mem_wr", {28'b0, mem_wr}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rresp_bresp", {28'b0, rresp, bresp}, 32'd0);
      check("rst_rlast", {31'b0, rlast}, 32'd0);
      rst = 0;
      @(negedge clk);

      for (int vi = 0; vi < 7; vi++) run_vec(vi, vecs[vi]);

      // Arbitration: last grant was a write, so a simultaneous request goes read first.
      err_op = -1; stall_cfg = 0; txn_base = log_addr.size();
      @(negedge clk);
      awvalid = 1; awaddr = 32'h700; awid = 4'h4; awlen = 8'd0; awburst = 2'b01;
      arvalid = 1; araddr = 32'h20; arid = 4'h7; arlen = 8'd0; arburst = 2'b01;
      #1;
      check("arb1_arready", {31'b0, arready}, 32'd1);
      check("arb1_awready", {31'b0, awready}, 32'd0);
      @(negedge clk);
      arvalid = 0;
      #1;
      check("arb1_awready_busy", {31'b0, awready}, 32'd0);
      wait_sig(4, "arb1_rvalid", cyc);
      check("arb1_rdata", rdata, 32'hC0DE_0008);
      rready = 1;
      @(negedge clk);
      rready = 0;
      arvalid = 1; araddr = 32'h24; arid = 4'h8;
      #1;
      check("arb2_awready", {31'b0, awready}, 32'd1);
      check("arb2_arready", {31'b0, arready}, 32'd0);
      wbase = log_addr.size();
      txn_base = wbase;
      @(negedge clk);
      awvalid = 0;
      wvalid = 1; wdata = 32'h77; wstrb = 4'hF; wlast = 1;
      wait_sig(2, "arb2_wready", cyc);
      @(negedge clk);
      wvalid = 0; wlast = 0; bready = 1;
      wait_sig(3, "arb2_bvalid", cyc);
      check("arb2_bid", {28'b0, bid}, 32'h4);
      @(negedge clk);
      bready = 0;
      check("arb2_mem_ops", log_addr.size() - wbase, 32'd1);
      if (log_addr.size() > wbase) check("arb2_mem_addr", log_addr[wbase], 32'h700);
      wait_sig(1, "arb3_arready", cyc);
      @(negedge clk);
      arvalid = 0;
      wait_sig(4, "arb3_rvalid", cyc);
      check("arb3_rdata", rdata, 32'hC0DE_0009);
      check("arb3_rid", {28'b0, rid}, 32'h8);
      rready = 1;
      @(negedge clk);
      rready = 0;
      $display("txn arb read/write/read grants checked");

      // Reset while the DUT waits for a read ack; the late ack must be ignored.
      no_ack = 1;
      arvalid = 1; araddr = 32'h80; arid = 4'h1; arlen = 8'd1; arburst = 2'b01;
      wait_sig(1, "rst_arready", cyc);
      @(negedge clk);
      arvalid = 0;
      @(negedge clk);
      check("rst_in_rd_wait", {31'b0, mem_rd}, 32'd0);
      rst = 1;
      @(negedge clk);
      check("midrst_rvalid", {31'b0, rvalid}, 32'd0);
      check("midrst_mem_rd", {31'b0, mem_rd}, 32'd0);
      check("midrst_mem_wr", {28'b0, mem_wr}, 32'd0);
      check("midrst_rdata", rdata, 32'd0);
      check("midrst_rlast", {31'b0, rlast}, 32'd0);
      rst = 0;
      no_ack = 0;
      force_ack = 1;
      @(negedge clk);
      force_ack = 0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (rvalid || mem_rd) seen = 1;
      end
      check("late_ack_ignored", {31'b0, seen}, 32'd0);
      $display("txn reset in RD_WAIT with late ack");

      run_vec(7, vecs[7]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
